// File: rtl/round_control.sv
// Duck Hunt round/wave sequencer. Launches waves of NUM_DUCKS ducks, spends
// shots, counts hits and escapes, and decides between the next round and
// game over once DUCKS_PER_ROUND ducks have flown.
module round_control #(
  parameter int NUM_DUCKS       = 2,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_WAVE  = 3,
  parameter int PASS_HITS       = 6,
  parameter int FLY_FRAMES      = 300,
  parameter int MAX_ROUND       = 99,
  localparam int SW = $clog2(SHOTS_PER_WAVE + 1),
  localparam int DW = $clog2(DUCKS_PER_ROUND + 1),
  localparam int TW = $clog2(FLY_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic                 trigger,
  input  logic [NUM_DUCKS-1:0] hit,
  input  logic [NUM_DUCKS-1:0] offscreen,
  output logic                 new_duck,
  output logic [NUM_DUCKS-1:0] launch_mask,
  output logic [NUM_DUCKS-1:0] duck_active,
  output logic                 escape,
  output logic [SW-1:0]        shots_left,
  output logic [DW-1:0]        ducks_done,
  output logic [DW-1:0]        hits,
  output logic [6:0]           round_num,
  output logic                 game_over,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_FLY       = 3'd2,
    S_ESCAPE    = 3'd3,
    S_TALLY     = 3'd4,
    S_ROUND_END = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  state_t          st;
  logic [TW-1:0]   timer;

  // FLY-cycle post-update values; exit decisions use these, not the old regs
  logic                 fire;
  logic [NUM_DUCKS-1:0] kills;
  logic [NUM_DUCKS-1:0] fly_active;
  logic [NUM_DUCKS-1:0] esc_active;
  logic [DW-1:0]        kill_cnt;
  logic [DW-1:0]        hits_fly;
  logic [SW-1:0]        shots_fly;
  logic [TW-1:0]        timer_fly;
  logic                 round_pass;
  logic [6:0]           round_inc;

  // Next-value arithmetic for shots, kills, timer and escapes
  always_comb begin
    fire       = trigger && (shots_left != '0);
    kills      = fire ? (hit & duck_active) : '0;
    fly_active = duck_active & ~kills;
    esc_active = duck_active & ~offscreen;
    kill_cnt   = '0;
    for (int i = 0; i < NUM_DUCKS; i++)
      if (kills[i]) kill_cnt = kill_cnt + DW'(1);
    hits_fly   = hits + kill_cnt;
    shots_fly  = shots_left - SW'(fire);
    timer_fly  = timer + TW'(frame_tick);
    round_pass = hits >= DW'(PASS_HITS);
    round_inc  = (round_num < 7'(MAX_ROUND)) ? round_num + 7'd1 : round_num;
  end

  // Sequencer: state plus all registered counters and masks
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      launch_mask <= '0;
      duck_active <= '0;
      shots_left  <= '0;
      ducks_done  <= '0;
      hits        <= '0;
      round_num   <= '0;
      timer       <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          launch_mask <= '0;
          duck_active <= '0;
          shots_left  <= '0;
          ducks_done  <= '0;
          hits        <= '0;
          round_num   <= '0;
          timer       <= '0;
          if (start) begin
            round_num   <= 7'd1;
            st          <= S_LAUNCH;
            launch_mask <= '1;
            duck_active <= '1;
            shots_left  <= SW'(SHOTS_PER_WAVE);
            ducks_done  <= DW'(NUM_DUCKS);
          end
        end
        S_LAUNCH: st <= S_FLY;
        S_FLY: begin
          duck_active <= fly_active;
          hits        <= hits_fly;
          shots_left  <= shots_fly;
          timer       <= timer_fly;
          // a kill on the last shot or timeout frame still counts as cleared
          if (fly_active == '0)
            st <= S_TALLY;
          else if (shots_fly == '0 || timer_fly >= TW'(FLY_FRAMES))
            st <= S_ESCAPE;
        end
        S_ESCAPE: begin
          duck_active <= esc_active;
          if (esc_active == '0) st <= S_TALLY;
        end
        S_TALLY: begin
          if (ducks_done == DW'(DUCKS_PER_ROUND)) begin
            st <= S_ROUND_END;
          end else begin
            st          <= S_LAUNCH;
            launch_mask <= '1;
            duck_active <= '1;
            shots_left  <= SW'(SHOTS_PER_WAVE);
            timer       <= '0;
            ducks_done  <= ducks_done + DW'(NUM_DUCKS);
          end
        end
        S_ROUND_END: begin
          if (round_pass) begin
            round_num   <= round_inc;
            hits        <= '0;
            st          <= S_LAUNCH;
            launch_mask <= '1;
            duck_active <= '1;
            shots_left  <= SW'(SHOTS_PER_WAVE);
            timer       <= '0;
            ducks_done  <= DW'(NUM_DUCKS);
          end else begin
            st <= S_GAME_OVER;
          end
        end
        S_GAME_OVER: begin
          // counters stay frozen for the score display until restart
          if (start) begin
            st          <= S_IDLE;
            launch_mask <= '0;
            duck_active <= '0;
            shots_left  <= '0;
            ducks_done  <= '0;
            hits        <= '0;
            round_num   <= '0;
            timer       <= '0;
          end
        end
        default: begin
          st          <= S_IDLE;
          launch_mask <= '0;
          duck_active <= '0;
          shots_left  <= '0;
          ducks_done  <= '0;
          hits        <= '0;
          round_num   <= '0;
          timer       <= '0;
        end
      endcase
    end
  end

  // State-decoded outputs
  assign state     = st;
  assign new_duck  = (st == S_LAUNCH);
  assign escape    = (st == S_ESCAPE);
  assign game_over = (st == S_GAME_OVER);

endmodule

// File: tb/tb_round_control.sv
// Randomised + directed bench for round_control with a behavioural game model.
module tb_round_control;
  localparam int FF = 4;

  logic       clk = 1'b0;
  logic       reset, start, frame_tick, trigger;
  logic [1:0] hit, offscreen;
  logic       new_duck, escape, game_over;
  logic [1:0] launch_mask, duck_active, shots_left;
  logic [3:0] ducks_done, hits;
  logic [6:0] round_num;
  logic [2:0] state;

  round_control #(.FLY_FRAMES(FF)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .trigger(trigger), .hit(hit), .offscreen(offscreen),
    .new_duck(new_duck), .launch_mask(launch_mask), .duck_active(duck_active),
    .escape(escape), .shots_left(shots_left), .ducks_done(ducks_done),
    .hits(hits), .round_num(round_num), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  // model of the game as a plain bookkeeping record
  int m_state = 0, m_shots = 0, m_done = 0, m_hits = 0, m_round = 0, m_timer = 0;
  logic [1:0] m_active = '0, m_mask = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_state = 0; m_shots = 0; m_done = 0; m_hits = 0; m_round = 0; m_timer = 0;
    m_active = '0; m_mask = '0;
  endtask

  task automatic m_new_wave();
    m_state = 1; m_mask = 2'b11; m_active = 2'b11; m_shots = 3; m_timer = 0;
    m_done += 2;
  endtask

  // one clock of game rules, applied to the inputs present at the edge
  task automatic model_step();
    logic [1:0] k;
    if (reset) begin m_clear(); return; end
    case (m_state)
      0: if (start) begin m_clear(); m_round = 1; m_new_wave(); end
      1: m_state = 2;
      2: begin
        k = (trigger && m_shots > 0) ? (hit & m_active) : 2'b00;
        if (trigger && m_shots > 0) m_shots--;
        m_active &= ~k;
        m_hits += $countones(k);
        if (frame_tick) m_timer++;
        if (m_active == 0) m_state = 4;
        else if (m_shots == 0 || m_timer >= FF) m_state = 3;
      end
      3: begin
        m_active &= ~offscreen;
        if (m_active == 0) m_state = 4;
      end
      4: if (m_done == 10) m_state = 5; else m_new_wave();
      5: if (m_hits >= 6) begin
           m_round = (m_round < 99) ? m_round + 1 : 99;
           m_hits = 0; m_done = 0; m_new_wave();
         end else m_state = 6;
      6: if (start) m_clear();
      default: m_clear();
    endcase
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("new_duck", new_duck, m_state == 1);
    chk("escape", escape, m_state == 3);
    chk("game_over", game_over, m_state == 6);
    chk("launch_mask", launch_mask, m_mask);
    chk("duck_active", duck_active, m_active);
    chk("shots_left", shots_left, m_shots);
    chk("ducks_done", ducks_done, m_done);
    chk("hits", hits, m_hits);
    chk("round_num", round_num, m_round);
  endtask

  task automatic drive(input logic rs, st, ft, tr, input logic [1:0] h, off);
    reset = rs; start = st; frame_tick = ft; trigger = tr; hit = h; offscreen = off;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic shoot(input logic [1:0] h);
    drive(0, 0, 0, 1, h, 2'b00);
  endtask

  // one wave starting in LAUNCH: up to three shots, then let escapees leave
  task automatic play_wave(input logic [1:0] first, input logic [1:0] second);
    idle();
    shoot(first);
    if (m_state == 2) shoot(second);
    if (m_state == 2) shoot(2'b00);
    if (m_state == 3) drive(0, 0, 0, 0, 2'b00, 2'b11);
    idle();
  endtask

  initial begin
    int guard;
    drive(1, 0, 0, 0, 2'b00, 2'b00);
    drive(1, 0, 0, 0, 2'b00, 2'b00);
    chk("reset_state", state, 0);
    chk("reset_round", round_num, 0);

    // double kill on one shot
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    chk("launch_mask_first", launch_mask, 2'b11);
    idle();
    shoot(2'b11);
    chk("double_hits", hits, 2);
    chk("double_shots", shots_left, 2);
    chk("double_tally", state, 4);
    idle();
    chk("relaunch", state, 1);

    // three misses -> escape, 4th trigger ignored, staggered offscreen
    idle();
    shoot(2'b00); shoot(2'b00); shoot(2'b00);
    chk("miss_escape", state, 3);
    chk("miss_shots", shots_left, 0);
    shoot(2'b11);
    chk("esc_trigger_hits", hits, 2);
    drive(0, 0, 0, 0, 2'b00, 2'b01);
    chk("off01_state", state, 3);
    chk("off01_active", duck_active, 2'b10);
    drive(0, 0, 0, 0, 2'b00, 2'b10);
    chk("off10_tally", state, 4);
    idle();

    // timeout after FF ticks
    idle();
    for (int i = 0; i < FF - 1; i++) drive(0, 0, 1, 0, 2'b00, 2'b00);
    chk("pre_timeout", state, 2);
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    chk("timeout_escape", state, 3);
    drive(0, 0, 0, 0, 2'b00, 2'b11);
    idle();
    // last duck killed on the timeout frame -> tally
    idle();
    drive(0, 0, 1, 1, 2'b01, 2'b00);
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    drive(0, 0, 1, 1, 2'b10, 2'b00);
    chk("timeout_kill_tally", state, 4);
    idle();

    // reset in the middle of a wave
    idle();
    shoot(2'b01);
    shoot(2'b00);
    chk("mid_shots", shots_left, 1);
    chk("mid_hits", hits, 5);
    drive(1, 0, 0, 0, 2'b00, 2'b00);
    chk("midrst_state", state, 0);
    chk("midrst_active", duck_active, 0);
    chk("midrst_hits", hits, 0);
    chk("midrst_done", ducks_done, 0);

    // passing round: 6 hits
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    for (int w = 0; w < 5; w++) play_wave(w < 3 ? 2'b11 : 2'b00, 2'b00);
    chk("round_end", state, 5);
    idle();
    chk("pass_round", round_num, 2);
    chk("pass_hits", hits, 0);
    // failing round: 5 hits
    play_wave(2'b11, 2'b00); play_wave(2'b11, 2'b00); play_wave(2'b01, 2'b00);
    play_wave(2'b00, 2'b00); play_wave(2'b00, 2'b00);
    idle();
    chk("fail_gameover", game_over, 1);
    chk("fail_hits_held", hits, 5);
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    chk("restart_idle", state, 0);

    // climb to the round cap and pass once more
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    guard = 0;
    while (m_round < 99 && guard < 120) begin
      for (int w = 0; w < 5; w++) play_wave(2'b11, 2'b00);
      if (m_state == 5) idle();
      guard++;
    end
    chk("reach_99", round_num, 99);
    for (int w = 0; w < 5; w++) play_wave(2'b11, 2'b00);
    idle();
    chk("sat_99", round_num, 99);
    chk("sat_state", state, 1);

    // random play
    drive(1, 0, 0, 0, 2'b00, 2'b00);
    for (int c = 0; c < 5000; c++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
